// File: rtl/md_sched.sv
// HI/LO multiply-divide sequencer: fixed-latency busy counter, pending result, ID-stage stall.
// Optional MD_FLUSH_EN adds a flush input that cancels the EX-stage md_op.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_uses_md,
`ifdef MD_FLUSH_EN
  input  logic        flush,
`endif
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic          dz_q, dz_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic op_valid;
`ifdef MD_FLUSH_EN
  assign op_valid = ~flush;
`else
  assign op_valid = 1'b1;
`endif

  logic is_mult, is_div, start_now, div_zero;
  assign is_mult   = (md_op == 3'd1) || (md_op == 3'd2);
  assign is_div    = (md_op == 3'd3) || (md_op == 3'd4);
  assign start_now = op_valid & (is_mult | is_div);
  assign div_zero  = (b == 32'd0);

  // Divisor forced to 1 on divide-by-zero so the datapath never sees x/0.
  logic signed [63:0] as64, bs64, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] as32, bs32, q_s, r_s;
  logic        [31:0] bsafe, q_u, r_u;
  logic        [63:0] res;

  assign as64   = {{32{a[31]}}, a};
  assign bs64   = {{32{b[31]}}, b};
  assign prod_s = as64 * bs64;
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign bsafe  = div_zero ? 32'd1 : b;
  assign as32   = a;
  assign bs32   = bsafe;
  assign q_s    = as32 / bs32;
  assign r_s    = as32 % bs32;
  assign q_u    = a / bsafe;
  assign r_u    = a % bsafe;

  always_comb begin
    res = 64'd0;
    case (md_op)
      3'd1:    res = prod_s;
      3'd2:    res = prod_u;
      3'd3:    res = {r_s, q_s};
      3'd4:    res = {r_u, q_u};
      default: res = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start_now) begin
          pend_d  = res;
          dz_d    = is_div & div_zero;
          cnt_d   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_d = RUN;
        end else if (op_valid && md_op == 3'd5) begin
          hi_d = a;
        end else if (op_valid && md_op == 3'd6) begin
          lo_d = a;
        end
      end
      RUN: begin
        // Any md_op arriving here is ignored; only the counter advances.
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (!dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 64'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = id_uses_md & (busy | start_now);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
